// File: rtl/dlx_pipe_if.sv
// DLX instruction fetch stage: drives the PC to instruction memory and fills the IF/ID register.
// Handles decode redirects, trap/illegal stops, pipeline hold and a multi-cycle memory handshake.
module dlx_pipe_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        dc_wait_i,
    input  logic        id_cond_i,
    input  logic [31:0] id_npc_i,
    input  logic        id_halt_i,
    input  logic        id_illegal_instr_i,
    output logic [31:0] im_adr_o,
    output logic        im_req_o,
    input  logic [31:0] im_rdata_i,
    input  logic        im_ack_i,
    output logic [31:0] if_id_npc_o,
    output logic [31:0] if_id_ir_o,
    output logic        if_halted_o,
    output logic        if_exc_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        pend_q, pend_d;
    logic        exc_q, exc_d;

    logic        hold;
    logic        stop;
    logic [31:0] tgt_in;
    logic [31:0] pc_inc;

    assign hold   = stall_i | dc_wait_i;
    assign stop   = id_halt_i | id_illegal_instr_i;
    assign tgt_in = {id_npc_i[31:2], 2'b00};
    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold) begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch, StWait: begin
                    if (stop) begin
                        state_d = StHalt;
                    end else if (im_ack_i) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StWait;
                    end
                end
                StHalt: state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    // Moore outputs: request stays up and address stable while held
    always_comb begin
        im_req_o    = (state_q == StFetch) || (state_q == StWait);
        im_adr_o    = pc_q;
        if_halted_o = (state_q == StHalt);
        if_id_ir_o  = ir_q;
        if_id_npc_o = npc_q;
        if_exc_o    = exc_q;
    end

    // Priority: stop > redirect > ack; an ack under a pending redirect only retires the request
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        npc_d  = npc_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        exc_d  = exc_q;
        if (!hold) begin
            unique case (state_q)
                StIdle: begin
                end
                StFetch, StWait: begin
                    ir_d = NOP_INSTR;
                    if (stop) begin
                        exc_d  = id_illegal_instr_i;
                        pend_d = 1'b0;
                    end else if (id_cond_i) begin
                        if (im_ack_i) begin
                            pc_d   = tgt_in;
                            pend_d = 1'b0;
                        end else begin
                            tgt_d  = tgt_in;
                            pend_d = 1'b1;
                        end
                    end else if (im_ack_i) begin
                        if (pend_q) begin
                            pc_d   = tgt_q;
                            pend_d = 1'b0;
                        end else begin
                            ir_d  = im_rdata_i;
                            npc_d = pc_inc;
                            pc_d  = pc_inc;
                        end
                    end
                end
                StHalt: ir_d = NOP_INSTR;
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            ir_q   <= NOP_INSTR;
            npc_q  <= RESET_PC;
            tgt_q  <= RESET_PC;
            pend_q <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            npc_q  <= npc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
            exc_q  <= exc_d;
        end
    end

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Self-checking bench for dlx_pipe_if: expected IF/ID contents are queued as each cycle's
// stimulus is driven and compared after the clock edge that produces them.
module tb_dlx_pipe_if;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i, dc_wait_i, id_cond_i, id_halt_i, id_illegal_instr_i;
    logic [31:0] id_npc_i;
    logic [31:0] im_adr_o;
    logic        im_req_o;
    logic [31:0] im_rdata_i;
    logic        im_ack_i;
    logic [31:0] if_id_npc_o, if_id_ir_o;
    logic        if_halted_o, if_exc_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb_q[$];

    dlx_pipe_if #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .stall_i            (stall_i),
        .dc_wait_i          (dc_wait_i),
        .id_cond_i          (id_cond_i),
        .id_npc_i           (id_npc_i),
        .id_halt_i          (id_halt_i),
        .id_illegal_instr_i (id_illegal_instr_i),
        .im_adr_o           (im_adr_o),
        .im_req_o           (im_req_o),
        .im_rdata_i         (im_rdata_i),
        .im_ack_i           (im_ack_i),
        .if_id_npc_o        (if_id_npc_o),
        .if_id_ir_o         (if_id_ir_o),
        .if_halted_o        (if_halted_o),
        .if_exc_o           (if_exc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC300_0000 ^ a;
    endfunction

    assign im_rdata_i = mem(im_adr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the IF/ID contents it must produce, then compare.
    task automatic step(input logic s, input logic dw, input logic a, input logic c,
                        input logic [31:0] t, input logic h, input logic il,
                        input logic [31:0] exp_ir, input logic [31:0] exp_npc);
        logic [63:0] e;
        stall_i = s; dc_wait_i = dw; im_ack_i = a; id_cond_i = c; id_npc_i = t;
        id_halt_i = h; id_illegal_instr_i = il;
        sb_q.push_back({exp_ir, exp_npc});
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("if_id_ir", if_id_ir_o, e[63:32]);
            check("if_id_npc", if_id_npc_o, e[31:0]);
        end
    endtask

    task automatic check_reset();
        check("rst_ir", if_id_ir_o, NOP);
        check("rst_npc", if_id_npc_o, 32'h0);
        check("rst_adr", im_adr_o, 32'h0);
        check("rst_req", {31'd0, im_req_o}, 32'd0);
        check("rst_halted", {31'd0, if_halted_o}, 32'd0);
        check("rst_exc", {31'd0, if_exc_o}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; stall_i = 0; dc_wait_i = 0; id_cond_i = 0; id_npc_i = 0;
        id_halt_i = 0; id_illegal_instr_i = 0; im_ack_i = 1'b1;
        #2;
        check_reset();
        #5 rst_ni = 1'b1;

        // Idle -> fetch, no request until after the first cycle
        step(0, 0, 1, 0, 0, 0, 0, NOP, 32'h0);
        check("idle_req", {31'd0, im_req_o}, 32'd1);
        check("idle_adr", im_adr_o, 32'h0);

        // Zero-wait sequential fetch
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h0), 32'h4);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h4), 32'h8);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h8), 32'hC);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'hC), 32'h10);
        check("seq_adr", im_adr_o, 32'h10);

        // Memory wait: bubbles, address held
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, NOP, 32'h10);
            check("wait_adr", im_adr_o, 32'h10);
            check("wait_req", {31'd0, im_req_o}, 32'd1);
        end
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h10), 32'h14);

        // Redirect with ack: squash, aligned target
        step(0, 0, 1, 1, 32'h0000_0103, 0, 0, NOP, 32'h14);
        check("redir_adr", im_adr_o, 32'h100);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h100), 32'h104);

        // Redirect during wait: late word dropped
        step(0, 0, 0, 0, 0, 0, 0, NOP, 32'h104);
        step(0, 0, 0, 1, 32'h40, 0, 0, NOP, 32'h104);
        check("pend_adr", im_adr_o, 32'h104);
        step(0, 0, 1, 0, 0, 0, 0, NOP, 32'h104);
        check("late_adr", im_adr_o, 32'h40);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h40), 32'h44);

        // Hold: stall and dc_wait freeze everything even with ack high
        step(1, 0, 1, 0, 0, 0, 0, mem(32'h40), 32'h44);
        step(1, 0, 1, 1, 32'h800, 1, 0, mem(32'h40), 32'h44);
        step(0, 1, 1, 0, 0, 0, 0, mem(32'h40), 32'h44);
        check("hold_adr", im_adr_o, 32'h44);
        check("hold_req", {31'd0, im_req_o}, 32'd1);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h44), 32'h48);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h48), 32'h4C);

        // PC wrap at the top of the address space
        step(0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0, NOP, 32'h4C);
        check("wrap_tgt", im_adr_o, 32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'hFFFF_FFFC), 32'h0);
        check("wrap_adr", im_adr_o, 32'h0);

        // Later redirect overwrites a pending one
        step(0, 0, 0, 1, 32'h200, 0, 0, NOP, 32'h0);
        step(0, 0, 0, 1, 32'h301, 0, 0, NOP, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, NOP, 32'h0);
        step(0, 0, 1, 0, 0, 0, 0, NOP, 32'h0);
        check("ovr_adr", im_adr_o, 32'h300);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h300), 32'h304);
        check("pre_exc", {31'd0, if_exc_o}, 32'd0);

        // Illegal instruction beats redirect and ack
        step(0, 0, 1, 1, 32'h500, 0, 1, NOP, 32'h304);
        check("ill_halted", {31'd0, if_halted_o}, 32'd1);
        check("ill_exc", {31'd0, if_exc_o}, 32'd1);
        check("ill_req", {31'd0, im_req_o}, 32'd0);
        step(0, 0, 1, 0, 0, 0, 0, NOP, 32'h304);
        check("halt_stay", {31'd0, if_halted_o}, 32'd1);

        // Reset mid-wait
        rst_ni = 1'b0;
        #1 rst_ni = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0, NOP, 32'h0);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h0), 32'h4);
        step(0, 0, 1, 0, 0, 0, 0, mem(32'h4), 32'h8);
        step(0, 0, 0, 0, 0, 0, 0, NOP, 32'h8);
        check("mid_adr", im_adr_o, 32'h8);
        #3 rst_ni = 1'b0;
        #1;
        check_reset();
        #2 rst_ni = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
